// File: rtl/multiply_pkg.sv
// Shared arithmetic datapath constants.
// State encoding and default width, common to multiplier and divider.
package multiply_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_RUN  = 2'd1,
    MUL_FIX  = 2'd2
  } mul_state_e;

endpackage

// File: rtl/multiply_if.sv
// Start/ready/done handshake bundle for the sequential multiplier.
// master = issuing control logic, slave = multiplier.
interface multiply_if
  import multiply_pkg::*;
#(
  parameter int WIDTH = DATA_W
);

  logic               start;
  logic               sign;
  logic [WIDTH-1:0]   multiplicand;
  logic [WIDTH-1:0]   multiplier;
  logic               ready;
  logic               done;
  logic [2*WIDTH-1:0] product;

  modport master (
    output start,
    output sign,
    output multiplicand,
    output multiplier,
    input  ready,
    input  done,
    input  product
  );

  modport slave (
    input  start,
    input  sign,
    input  multiplicand,
    input  multiplier,
    output ready,
    output done,
    output product
  );

endinterface

// File: rtl/multiply_twos_abs.sv
// Combinational two's-complement magnitude; the most negative value
// maps to 2^(WIDTH-1), which is correct when read as unsigned.
module twos_abs #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] in_i,
  input  logic             sign_en_i,
  output logic [WIDTH-1:0] out_o,
  output logic             is_neg_o
);

  assign is_neg_o = sign_en_i & in_i[WIDTH-1];
  assign out_o    = is_neg_o ? (~in_i + WIDTH'(1)) : in_i;

endmodule

// File: rtl/multiply.sv
// Sequential shift-add multiplier, one multiplier bit per cycle,
// magnitudes multiplied then sign fixed up in a final cycle.
module multiply
  import multiply_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic     clk,
  input  logic     rst,
  multiply_if.slave bus
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam int PW = 2 * WIDTH;

  mul_state_e     state_q, state_d;
  logic [CW-1:0]  count_q, count_d;
  logic [PW-1:0]  mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [PW-1:0]  acc_q, acc_d;
  logic           neg_q, neg_d;
  logic [PW-1:0]  product_q, product_d;
  logic           done_q, done_d;

  logic [WIDTH-1:0] abs_a, abs_b;
  logic             neg_a, neg_b;

  twos_abs #(.WIDTH(WIDTH)) u_abs_a (
    .in_i      (bus.multiplicand),
    .sign_en_i (bus.sign),
    .out_o     (abs_a),
    .is_neg_o  (neg_a)
  );

  twos_abs #(.WIDTH(WIDTH)) u_abs_b (
    .in_i      (bus.multiplier),
    .sign_en_i (bus.sign),
    .out_o     (abs_b),
    .is_neg_o  (neg_b)
  );

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    neg_d     = neg_q;
    product_d = product_q;
    done_d    = 1'b0;
    unique case (state_q)
      MUL_IDLE: begin
        if (bus.start) begin
          mcand_d  = {{WIDTH{1'b0}}, abs_a};
          mplier_d = abs_b;
          acc_d    = '0;
          count_d  = CW'(WIDTH);
          neg_d    = neg_a ^ neg_b;
          state_d  = MUL_RUN;
        end
      end
      MUL_RUN: begin
        if (mplier_q[0])
          acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        count_d  = count_q - CW'(1);
        if (count_q == CW'(1))
          state_d = MUL_FIX;
      end
      MUL_FIX: begin
        // ~0+1 wraps back to 0, so a zero magnitude stays zero
        product_d = neg_q ? (~acc_q + PW'(1)) : acc_q;
        done_d    = 1'b1;
        state_d   = MUL_IDLE;
      end
      default: state_d = MUL_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= MUL_IDLE;
      count_q   <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      neg_q     <= 1'b0;
      product_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      neg_q     <= neg_d;
      product_q <= product_d;
      done_q    <= done_d;
    end
  end

  assign bus.ready   = (state_q == MUL_IDLE);
  assign bus.done    = done_q;
  assign bus.product = product_q;

endmodule

// File: tb/tb_multiply.sv
// Directed and random checks of the sequential multiplier.
module tb_multiply;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   accepted;
  int   done_cnt;

  multiply_if #(.WIDTH(32)) bus ();

  multiply #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk)
    if (bus.done === 1'b1) done_cnt++;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // waits for done after an accept edge; returns edge count (41 = timeout)
  task automatic wait_done(output int k, output logic busy_ok);
    k = 0;
    busy_ok = 1'b1;
    while (k < 41) begin
      @(posedge clk); #1;
      k++;
      if (bus.done === 1'b1) break;
      if (bus.ready !== 1'b0) busy_ok = 1'b0;
    end
  endtask

  task automatic run_op(input string tag,
                        input logic sg,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic [63:0] exp);
    int   k;
    logic bz;
    @(negedge clk);
    bus.sign = sg;
    bus.multiplicand = a;
    bus.multiplier = b;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    accepted++;
    wait_done(k, bz);
    chk({tag, "_lat"}, 64'(k), 64'd33);
    chk({tag, "_busy"}, 64'(bz), 64'd1);
    chk({tag, "_prod"}, bus.product, exp);
    chk({tag, "_rdy"}, 64'(bus.ready), 64'd1);
  endtask

  initial begin
    int          k;
    logic        bz;
    logic [31:0] ra, rb;
    logic        rs;
    logic [63:0] gold;

    checks = 0;
    errors = 0;
    accepted = 0;
    done_cnt = 0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.sign = 1'b0;
    bus.multiplicand = '0;
    bus.multiplier = '0;
    #2;
    chk("rst_ready", 64'(bus.ready), 64'd1);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_prod", bus.product, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_op("u7x6", 1'b0, 32'd7, 32'd6, 64'h0000_0000_0000_002A);
    run_op("s_m7x6", 1'b1, 32'hFFFF_FFF9, 32'd6, 64'hFFFF_FFFF_FFFF_FFD6);
    run_op("u_m7x6", 1'b0, 32'hFFFF_FFF9, 32'd6, 64'h0000_0005_FFFF_FFD6);
    run_op("u_max", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    run_op("s_minmin", 1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
    run_op("s_minx1", 1'b1, 32'h8000_0000, 32'd1, 64'hFFFF_FFFF_8000_0000);
    run_op("s_zero", 1'b1, 32'd0, 32'hFFFF_FFFB, 64'd0);

    // start held and operands toggled while busy
    @(negedge clk);
    bus.sign = 1'b0;
    bus.multiplicand = 32'h1234;
    bus.multiplier = 32'h10;
    bus.start = 1'b1;
    @(posedge clk); #1;
    accepted++;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      bus.multiplicand = $urandom;
      bus.multiplier = $urandom;
      bus.sign = ~bus.sign;
    end
    bus.start = 1'b0;
    k = 0;
    while (k < 40 && bus.done !== 1'b1) begin
      @(posedge clk); #1;
      k++;
    end
    chk("hold_done", 64'(bus.done), 64'd1);
    chk("hold_prod", bus.product, 64'h0000_0000_0001_2340);

    // back-to-back: start issued during the done cycle
    @(negedge clk);
    bus.sign = 1'b0;
    bus.multiplicand = 32'd3;
    bus.multiplier = 32'd5;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    accepted++;
    chk("b2b_rdy", 64'(bus.ready), 64'd0);
    chk("b2b_done", 64'(bus.done), 64'd0);
    chk("b2b_hold", bus.product, 64'h0000_0000_0001_2340);
    wait_done(k, bz);
    chk("b2b_lat", 64'(k), 64'd33);
    chk("b2b_prod", bus.product, 64'd15);

    // asynchronous reset in the middle of an operation
    @(negedge clk);
    bus.multiplicand = 32'd9;
    bus.multiplier = 32'd9;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_ready", 64'(bus.ready), 64'd1);
    chk("arst_done", 64'(bus.done), 64'd0);
    chk("arst_prod", bus.product, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op("post_rst", 1'b0, 32'd100, 32'd200, 64'd20000);

    for (int n = 0; n < 1000; n++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      rs = 1'($urandom_range(0, 1));
      ra = $urandom;
      rb = $urandom;
      if (n % 7 == 0) ra = 32'h8000_0000;
      if (n % 11 == 0) rb = 32'hFFFF_FFFF;
      if (rs)
        gold = {{32{ra[31]}}, ra} * {{32{rb[31]}}, rb};
      else
        gold = {32'd0, ra} * {32'd0, rb};
      run_op("rand", rs, ra, rb, gold);
    end

    repeat (3) @(negedge clk);
    chk("done_count", 64'(done_cnt), 64'(accepted));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multiply.md
Name: multiply

Overview:
- Sequential shift-add integer multiplier, WIDTH x WIDTH -> 2*WIDTH product.
- Signed (two's complement) or unsigned operation, selected per operation by the "sign" input.
- Companion to the sequential divider in the arithmetic datapath; same ready-based, one-bit-per-cycle iterative style.
- Fixed latency; start/ready/done handshake toward the issuing control logic.

Parameters:
- WIDTH, 32, operand width in bits; product is 2*WIDTH.

Ports:
- clk  input  1  single clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; accepted only on an edge where ready=1.
- sign  input  1  1 = signed two's complement, 0 = unsigned; sampled at accept.
- multiplicand  input  WIDTH  operand A; sampled at accept.
- multiplier  input  WIDTH  operand B; sampled at accept.
- ready  output  1  1 when idle and able to accept; combinational from state.
- done  output  1  one-cycle pulse when product is valid.
- product  output  2*WIDTH  result register; holds last result until next completion.

Behaviour:
- Reset (async, any time, including mid-operation): state=IDLE, product=0, done=0, ready=1, counter=0, internal copies=0. Abort in progress; no partial result is exposed.
- States:
  - IDLE: ready=1.
  - RUN: ready=0.
  - FIX: ready=0.
- IDLE, start=1 at edge E0:
  - mcand_copy[2W-1:0] = {0, |A|}; mplier_copy = |B|; acc = 0; count = WIDTH.
  - neg = sign & (A[W-1] ^ B[W-1]).
  - |x| = x when sign=0 or x[W-1]=0, else ~x+1. 0x80000000 magnitude is 2^31, which is correct as unsigned.
  - Go to RUN.
- RUN, one iteration per edge (E1..E_WIDTH):
  - If mplier_copy[0], then acc += mcand_copy (2W-bit add, no overflow possible).
  - mcand_copy <<= 1; mplier_copy >>= 1; count -= 1.
  - When count reaches 0, go to FIX.
- FIX, edge E_(WIDTH+1):
  - product = neg ? (~acc + 1) : acc; done=1 for exactly this one cycle; state to IDLE.
  - ready and done are both high in the cycle after this edge.
- Latency: done is high WIDTH+1 edges after the accepting edge (33 for WIDTH=32). No early termination on zero operands; latency is fixed.
- Back-to-back: start=1 while done=1 (ready=1) is accepted, so there is no bubble. done drops on the next edge. product holds the previous result until the next FIX.
- start while ready=0: ignored, with no effect. Operand/sign changes while busy: ignored; values are captured at accept only.
- Zero product with neg=1 yields 0 (~0+1 wraps to 0).
- done is never asserted without a preceding accepted start since reset.

Decomposition:
- Shared arithmetic package/include holds:
  - State encoding constants MUL_IDLE=2'd0, MUL_RUN=2'd1, MUL_FIX=2'd2.
  - Default datapath width constant (32), shared with the divider.
- One natural sub-module: twos_abs (WIDTH-param combinational magnitude: in, sign_en -> out, is_neg). It is instantiated twice here and is reusable by the divider.
- Counter width is clog2(WIDTH)+1 and is local.

Test Plan:
- Reset, then sign=0, A=7, B=6, start pulse -> product=0x00000000_0000002A, with done exactly 33 edges after accept, ready=0 during 32 RUN + FIX edges.
- A=0xFFFFFFF9, B=6:
  - sign=1 -> product=0xFFFFFFFF_FFFFFFD6.
  - sign=0 -> product=0x00000005_FFFFFFD6.
- Extremes:
  - Unsigned 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE_00000001.
  - Signed 0x80000000*0x80000000 -> 0x40000000_00000000.
  - Signed 0x80000000*1 -> 0xFFFFFFFF_80000000.
  - Signed 0*0xFFFFFFFB -> 0.
- Handshake:
  - start held high and operands toggled during RUN -> ignored, result matches captured operands.
  - New start (A=3,B=5) asserted in the done cycle -> accepted, ready=0 next cycle, first product held until second done gives 15.
- rst asserted asynchronously mid-cycle at iteration 10 -> immediately ready=1, done=0, product=0 (no clock needed); subsequent op A=100,B=200 -> 20000.
- Random: 1000 ops, random sign/operands, random start gaps -> product matches 64-bit golden model; exactly one done per accepted start.
